// File: rtl/perfect_6502_pkg.sv
// perfect_6502_pkg: shared types and constants for the reduced 6502 core.
//   state_e   - bus-cycle sequencer states
//   alu_op_e  - ALU operation select (pass-through or increment)
//   OP_*      - supported opcode encodings
//   P_RESET   - processor status value loaded by reset
package perfect_6502_pkg;

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    FETCH,
    OP1,
    OP2,
    WR
  } state_e;

  typedef enum logic {
    ALU_PASS,
    ALU_INC
  } alu_op_e;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;

  localparam logic [7:0] P_RESET = 8'h34;

  // Replace N (bit 7) and Z (bit 1) of a status byte, keeping the rest.
  function automatic logic [7:0] set_nz(input logic [7:0] p, input logic n, input logic z);
    return {n, p[6:2], z, p[0]};
  endfunction

endpackage

// File: rtl/perfect_6502_if.sv
// perfect_6502_if: CPU bus signals other than the tri-state data bus.
//   ready        - RDY, read cycles stall while low (slave -> master)
//   irq/nmi/so   - interrupt and set-overflow inputs (slave -> master)
//   sync         - opcode-fetch indicator (master -> slave)
//   readNotWrite - 1 = read cycle, 0 = write cycle (master -> slave)
//   address      - 16-bit bus address (master -> slave)
interface perfect_6502_if;

  logic        ready;
  logic        irq;
  logic        nmi;
  logic        so;
  logic        sync;
  logic        readNotWrite;
  logic [15:0] address;

  modport master (
    input  ready,
    input  irq,
    input  nmi,
    input  so,
    output sync,
    output readNotWrite,
    output address
  );

  modport slave (
    output ready,
    output irq,
    output nmi,
    output so,
    input  sync,
    input  readNotWrite,
    input  address
  );

endinterface

// File: rtl/perfect_6502_alu.sv
// perfect_6502_alu: combinational 8-bit pass/increment unit.
//   i_op      - ALU_PASS forwards the operand, ALU_INC adds one (mod 256)
//   i_operand - 8-bit input
//   o_result  - 8-bit result
//   o_n       - result[7]
//   o_z       - result == 0
module perfect_6502_alu
  import perfect_6502_pkg::*;
(
  input  alu_op_e    i_op,
  input  logic [7:0] i_operand,
  output logic [7:0] o_result,
  output logic       o_n,
  output logic       o_z
);

  always_comb begin
    o_result = i_operand;
    if (i_op == ALU_INC) begin
      o_result = i_operand + 8'd1;
    end
  end

  assign o_n = o_result[7];
  assign o_z = (o_result == 8'h00);

endmodule

// File: rtl/perfect_6502.sv
// perfect_6502: reduced NMOS 6502 bus master (reset vector, NOP, LDA#, LDX#, INX, JMP abs,
// STA abs; any other opcode is a 2-cycle NOP).
//   clock0 - master clock, state changes on its rising edge
//   reset  - asynchronous active-low reset
//   clock1 - phi1 = ~clock0
//   clock2 - phi2 = clock0
//   data   - bidirectional data bus, driven only in write cycles
//   bus    - address, readNotWrite, sync, ready and the (ignored) irq/nmi/so
module perfect_6502
  import perfect_6502_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic               clock0,
  input  logic               reset,
  output logic               clock1,
  output logic               clock2,
  inout  wire  [7:0]         data,
  perfect_6502_if.master     bus
);

  state_e      r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic [7:0]  r_a, w_a_d;
  logic [7:0]  r_x, w_x_d;
  logic [7:0]  r_p, w_p_d;
  logic [7:0]  r_ir, w_ir_d;
  logic [7:0]  r_lo, w_lo_d;
  logic [7:0]  r_hi, w_hi_d;

  logic [15:0] w_pc_inc;
  logic        w_advance;
  alu_op_e     w_alu_op;
  logic [7:0]  w_alu_in;
  logic [7:0]  w_alu_result;
  logic        w_alu_n;
  logic        w_alu_z;
  logic        w_unused;

  // Sink for irq, nmi and so, which have no effect on the core.
  assign w_unused = ^{bus.irq, bus.nmi, bus.so};

  assign clock1 = ~clock0;
  assign clock2 = clock0;

  // RDY only stalls reads; a write cycle always completes.
  assign w_advance = bus.ready | (r_state == WR);
  assign w_pc_inc  = r_pc + 16'd1;

  assign w_alu_op = (r_ir == OP_INX) ? ALU_INC : ALU_PASS;
  assign w_alu_in = (r_ir == OP_INX) ? r_x : data;

  perfect_6502_alu u_alu (
    .i_op      (w_alu_op),
    .i_operand (w_alu_in),
    .o_result  (w_alu_result),
    .o_n       (w_alu_n),
    .o_z       (w_alu_z)
  );

  // Bus outputs decode from state alone, so an asynchronous reset returns the bus to the
  // vector fetch at once and a stall holds everything still.
  always_comb begin
    bus.address = r_pc;
    case (r_state)
      RST_LO:  bus.address = RESET_VECTOR;
      RST_HI:  bus.address = RESET_VECTOR + 16'd1;
      WR:      bus.address = {r_hi, r_lo};
      default: bus.address = r_pc;
    endcase
  end

  assign bus.sync         = (r_state == FETCH);
  assign bus.readNotWrite = (r_state != WR);
  assign data             = (r_state == WR) ? r_a : 8'hzz;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_a_d     = r_a;
    w_x_d     = r_x;
    w_p_d     = r_p;
    w_ir_d    = r_ir;
    w_lo_d    = r_lo;
    w_hi_d    = r_hi;
    if (w_advance) begin
      case (r_state)
        RST_LO: begin
          w_pc_d[7:0] = data;
          w_state_d   = RST_HI;
        end
        RST_HI: begin
          w_pc_d[15:8] = data;
          w_state_d    = FETCH;
        end
        FETCH: begin
          w_ir_d    = data;
          w_pc_d    = w_pc_inc;
          w_state_d = OP1;
        end
        OP1: begin
          w_state_d = FETCH;
          case (r_ir)
            OP_LDA_IMM: begin
              w_a_d  = w_alu_result;
              w_p_d  = set_nz(r_p, w_alu_n, w_alu_z);
              w_pc_d = w_pc_inc;
            end
            OP_LDX_IMM: begin
              w_x_d  = w_alu_result;
              w_p_d  = set_nz(r_p, w_alu_n, w_alu_z);
              w_pc_d = w_pc_inc;
            end
            OP_INX: begin
              w_x_d = w_alu_result;
              w_p_d = set_nz(r_p, w_alu_n, w_alu_z);
            end
            OP_JMP_ABS, OP_STA_ABS: begin
              w_lo_d    = data;
              w_pc_d    = w_pc_inc;
              w_state_d = OP2;
            end
            OP_NOP: ;
            default: ;  // unsupported opcode: dummy read, nothing changes
          endcase
        end
        OP2: begin
          if (r_ir == OP_STA_ABS) begin
            w_hi_d    = data;
            w_pc_d    = w_pc_inc;
            w_state_d = WR;
          end else begin
            w_pc_d    = {data, r_lo};
            w_state_d = FETCH;
          end
        end
        WR:      w_state_d = FETCH;
        default: w_state_d = RST_LO;
      endcase
    end
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      r_state <= RST_LO;
      r_pc    <= 16'h0000;
      r_a     <= 8'h00;
      r_x     <= 8'h00;
      r_p     <= P_RESET;
      r_ir    <= 8'h00;
      r_lo    <= 8'h00;
      r_hi    <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_a     <= w_a_d;
      r_x     <= w_x_d;
      r_p     <= w_p_d;
      r_ir    <= w_ir_d;
      r_lo    <= w_lo_d;
      r_hi    <= w_hi_d;
    end
  end

endmodule

// File: tb/tb_perfect_6502.sv
// tb_perfect_6502: directed self-checking bench for perfect_6502 with a 64 KiB memory model.
module tb_perfect_6502;

  logic        clock0;
  logic        reset;
  logic        clock1;
  logic        clock2;
  wire  [7:0]  data;
  logic [7:0]  mem [0:65535];

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_count = 0;
  logic [15:0] wr_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;

  perfect_6502_if bus ();

  perfect_6502 #(
    .RESET_VECTOR (16'hFFFC)
  ) dut (
    .clock0 (clock0),
    .reset  (reset),
    .clock1 (clock1),
    .clock2 (clock2),
    .data   (data),
    .bus    (bus)
  );

  // Memory answers every read cycle; writes are logged rather than stored.
  assign data = bus.readNotWrite ? mem[bus.address] : 8'hzz;

  always @(posedge clock0) begin
    if (reset && !bus.readNotWrite) begin
      wr_count <= wr_count + 1;
      wr_addr  <= bus.address;
      wr_data  <= data;
    end
  end

  initial begin
    clock0 = 1'b0;
    forever #5 clock0 = ~clock0;
  end

  task automatic tick;
    @(posedge clock0);
    @(negedge clock0);
  endtask

  // Reset, then run the vector fetch so the bench sits in the FETCH cycle at 8000.
  task automatic go_fetch;
    reset = 1'b0;
    repeat (2) @(negedge clock0);
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock0);
      n_vec++;
      if ({bus.address, bus.readNotWrite, bus.sync, clock1, clock2} !==
          {16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_bus: addr=%h rnw=%b sync=%b c1=%b c2=%b want FFFC 1 0 1 0",
                 bus.address, bus.readNotWrite, bus.sync, clock1, clock2);
      end
    end
    n_vec++;
    if ({dut.r_a, dut.r_x, dut.r_p, dut.r_pc} !== {8'h00, 8'h00, 8'h34, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_regs: A=%h X=%h P=%h PC=%h want 00 00 34 0000",
               dut.r_a, dut.r_x, dut.r_p, dut.r_pc);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.address, bus.sync} !== {16'hFFFC, 1'b0}) begin
      n_err++;
      $display("FAIL reset_cyc1: addr=%h sync=%b want FFFC 0", bus.address, bus.sync);
    end
    @(posedge clock0);
    #1;
    n_vec++;
    if ({clock1, clock2} !== 2'b01) begin
      n_err++;
      $display("FAIL phase_high: c1=%b c2=%b want 0 1", clock1, clock2);
    end
    @(negedge clock0);
    n_vec++;
    if ({bus.address, bus.sync} !== {16'hFFFD, 1'b0}) begin
      n_err++;
      $display("FAIL reset_cyc2: addr=%h sync=%b want FFFD 0", bus.address, bus.sync);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync, bus.readNotWrite} !== {16'h8000, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_cyc3: addr=%h sync=%b rnw=%b want 8000 1 1",
               bus.address, bus.sync, bus.readNotWrite);
    end
  endtask

  task automatic test_lda_sta;
    int wc;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h5A;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
    bus.irq = 1'b0;  // must have no effect
    go_fetch();
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h8001, 1'b0}) begin
      n_err++;
      $display("FAIL lda_operand: addr=%h sync=%b want 8001 0", bus.address, bus.sync);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync, dut.r_a, dut.r_p} !== {16'h8002, 1'b1, 8'h5A, 8'h34}) begin
      n_err++;
      $display("FAIL sta_fetch: addr=%h sync=%b A=%h P=%h want 8002 1 5A 34",
               bus.address, bus.sync, dut.r_a, dut.r_p);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync, bus.readNotWrite} !== {16'h8003, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL sta_lo: addr=%h sync=%b rnw=%b want 8003 0 1",
               bus.address, bus.sync, bus.readNotWrite);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.readNotWrite} !== {16'h8004, 1'b1}) begin
      n_err++;
      $display("FAIL sta_hi: addr=%h rnw=%b want 8004 1", bus.address, bus.readNotWrite);
    end
    wc = wr_count;
    tick();
    n_vec++;
    if ({bus.address, bus.readNotWrite, bus.sync, data} !== {16'h1234, 1'b0, 1'b0, 8'h5A}) begin
      n_err++;
      $display("FAIL sta_write: addr=%h rnw=%b sync=%b data=%h want 1234 0 0 5A",
               bus.address, bus.readNotWrite, bus.sync, data);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h8005, 1'b1}) begin
      n_err++;
      $display("FAIL sta_next: addr=%h sync=%b want 8005 1", bus.address, bus.sync);
    end
    n_vec++;
    if ({wr_count - wc, wr_addr, wr_data} !== {32'd1, 16'h1234, 8'h5A}) begin
      n_err++;
      $display("FAIL sta_log: writes=%0d addr=%h data=%h want 1 1234 5A",
               wr_count - wc, wr_addr, wr_data);
    end
    bus.irq = 1'b1;
  endtask

  task automatic test_jmp;
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h90;
    go_fetch();
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h8001, 1'b0}) begin
      n_err++;
      $display("FAIL jmp_lo: addr=%h sync=%b want 8001 0", bus.address, bus.sync);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h8002, 1'b0}) begin
      n_err++;
      $display("FAIL jmp_hi: addr=%h sync=%b want 8002 0", bus.address, bus.sync);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h9000, 1'b1}) begin
      n_err++;
      $display("FAIL jmp_target: addr=%h sync=%b want 9000 1", bus.address, bus.sync);
    end
  endtask

  task automatic test_inx_wrap;
    mem[16'h8000] = 8'hA2; mem[16'h8001] = 8'hFF; mem[16'h8002] = 8'hE8;
    go_fetch();
    tick();
    tick();
    n_vec++;
    if ({bus.address, dut.r_x, dut.r_p} !== {16'h8002, 8'hFF, 8'hB4}) begin
      n_err++;
      $display("FAIL ldx_ff: addr=%h X=%h P=%h want 8002 FF B4", bus.address, dut.r_x, dut.r_p);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h8003, 1'b0}) begin
      n_err++;
      $display("FAIL inx_dummy: addr=%h sync=%b want 8003 0", bus.address, bus.sync);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync, dut.r_x, dut.r_p} !== {16'h8003, 1'b1, 8'h00, 8'h36}) begin
      n_err++;
      $display("FAIL inx_wrap: addr=%h sync=%b X=%h P=%h want 8003 1 00 36",
               bus.address, bus.sync, dut.r_x, dut.r_p);
    end
  endtask

  task automatic test_unknown;
    mem[16'h8000] = 8'h02;
    mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'hC3; mem[16'h8003] = 8'h02;
    go_fetch();
    tick();
    n_vec++;
    if ({bus.address, bus.sync, bus.readNotWrite} !== {16'h8001, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL unk_dummy: addr=%h sync=%b rnw=%b want 8001 0 1",
               bus.address, bus.sync, bus.readNotWrite);
    end
    tick();
    n_vec++;
    if ({bus.address, bus.sync, dut.r_a, dut.r_x, dut.r_p} !==
        {16'h8001, 1'b1, 8'h00, 8'h00, 8'h34}) begin
      n_err++;
      $display("FAIL unk_reset_regs: addr=%h sync=%b A=%h X=%h P=%h want 8001 1 00 00 34",
               bus.address, bus.sync, dut.r_a, dut.r_x, dut.r_p);
    end
    repeat (4) tick();
    n_vec++;
    if ({bus.address, bus.sync, dut.r_a, dut.r_x, dut.r_p} !==
        {16'h8004, 1'b1, 8'hC3, 8'h00, 8'hB4}) begin
      n_err++;
      $display("FAIL unk_loaded_regs: addr=%h sync=%b A=%h X=%h P=%h want 8004 1 C3 00 B4",
               bus.address, bus.sync, dut.r_a, dut.r_x, dut.r_p);
    end
  endtask

  task automatic test_stall;
    int wc;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h5A;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
    go_fetch();
    tick();
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({bus.address, bus.sync, dut.r_a, dut.r_pc} !== {16'h8001, 1'b0, 8'h00, 16'h8001}) begin
        n_err++;
        $display("FAIL stall_hold: addr=%h sync=%b A=%h PC=%h want 8001 0 00 8001",
                 bus.address, bus.sync, dut.r_a, dut.r_pc);
      end
    end
    bus.ready = 1'b1;
    tick();
    n_vec++;
    if ({bus.address, bus.sync, dut.r_a} !== {16'h8002, 1'b1, 8'h5A}) begin
      n_err++;
      $display("FAIL stall_resume: addr=%h sync=%b A=%h want 8002 1 5A",
               bus.address, bus.sync, dut.r_a);
    end
    tick();
    tick();
    tick();
    // Write cycle with RDY low must still complete.
    bus.ready = 1'b0;
    wc = wr_count;
    tick();
    n_vec++;
    if ({bus.address, bus.sync, wr_count - wc, wr_data} !== {16'h8005, 1'b1, 32'd1, 8'h5A}) begin
      n_err++;
      $display("FAIL stall_write: addr=%h sync=%b writes=%0d data=%h want 8005 1 1 5A",
               bus.address, bus.sync, wr_count - wc, wr_data);
    end
    bus.ready = 1'b1;
  endtask

  task automatic test_abort;
    int wc;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h5A;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h78; mem[16'h8004] = 8'h56;
    go_fetch();
    repeat (4) tick();
    n_vec++;
    if (bus.address !== 16'h8004) begin
      n_err++;
      $display("FAIL abort_setup: addr=%h want 8004", bus.address);
    end
    wc = wr_count;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.address, bus.readNotWrite, bus.sync} !== {16'hFFFC, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL abort_bus: addr=%h rnw=%b sync=%b want FFFC 1 0",
               bus.address, bus.readNotWrite, bus.sync);
    end
    repeat (3) tick();
    n_vec++;
    if (wr_count - wc !== 0) begin
      n_err++;
      $display("FAIL abort_nowrite: writes=%0d want 0", wr_count - wc);
    end
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus.address, bus.sync} !== {16'h8000, 1'b1}) begin
      n_err++;
      $display("FAIL abort_restart: addr=%h sync=%b want 8000 1", bus.address, bus.sync);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    reset     = 1'b0;
    bus.ready = 1'b1;
    bus.irq   = 1'b1;
    bus.nmi   = 1'b1;
    bus.so    = 1'b0;
    test_reset();
    test_lda_sta();
    test_jmp();
    test_inx_wrap();
    test_unknown();
    test_stall();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
